// File: rtl/icache_pkg.sv
// icache_pkg: shared widths and FSM encoding for the direct-mapped instruction cache.
package icache_pkg;
   localparam int ICACHE_ADDR_W   = 25;
   localparam int ICACHE_DATA_W   = 32;
   localparam int ICACHE_BYTE_W   = 4;
   localparam int ICACHE_OFFSET_W = 2;
   localparam int ICACHE_INDEX_W  = 6;
   localparam int ICACHE_TAG_W    = ICACHE_ADDR_W - ICACHE_INDEX_W - ICACHE_OFFSET_W;
   localparam logic [ICACHE_DATA_W-1:0] ICACHE_ZERO_WORD = '0;
   typedef enum logic [2:0] {
      ICACHE_IDLE,
      ICACHE_LOOKUP,
      ICACHE_MISS_REQ,
      ICACHE_REFILL,
      ICACHE_RESPOND
   } icache_state_e;
endpackage

// File: rtl/icache_ram.sv
// icache_ram: simple dual-port RAM, one write port and one synchronous read port.
module icache_ram #(
   parameter int W = 32,
   parameter int D = 256,
   localparam int AW = $clog2(D)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [D];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache; 1-cycle hits, burst line refill on miss.
module icache import icache_pkg::*; #(
   parameter int ADDR_W   = ICACHE_ADDR_W,
   parameter int DATA_W   = ICACHE_DATA_W,
   parameter int OFFSET_W = ICACHE_OFFSET_W,
   parameter int INDEX_W  = ICACHE_INDEX_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDR_W-1:0]    i_p_addr,
   input  logic                 i_p_read,
   input  logic                 i_p_write,
   input  logic [3:0]           i_p_byte_en,
   input  logic [DATA_W-1:0]    i_p_writedata,
   output logic [DATA_W-1:0]    o_p_readdata,
   output logic                 o_p_readdata_valid,
   output logic                 o_p_waitrequest,
   input  logic                 i_invalidate,
   output logic [ADDR_W-1:0]    o_m_addr,
   output logic                 o_m_read,
   output logic [2:0]           o_m_burstcount,
   input  logic [DATA_W-1:0]    i_m_readdata,
   input  logic                 i_m_readdata_valid,
   input  logic                 i_m_waitrequest
);
   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
   icache_state_e state, nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [2**INDEX_W-1:0] valid;
   logic [OFFSET_W-1:0] beat;
   logic taint;
   logic [DATA_W-1:0] ret, data_rd;
   logic [TAG_W-1:0] tag_rd;
   logic hit, miss, beat_ok, last, accept;
   logic unused_ok;
   wire [OFFSET_W-1:0] off_q = addr_q[OFFSET_W-1:0];
   wire [INDEX_W-1:0]  idx_q = addr_q[OFFSET_W +: INDEX_W];
   wire [TAG_W-1:0]    tag_q = addr_q[ADDR_W-1 -: TAG_W];
   assign unused_ok = ^{i_p_write, i_p_byte_en, i_p_writedata};
   assign hit     = state == ICACHE_LOOKUP && valid[idx_q] && tag_rd == tag_q;
   assign miss    = state == ICACHE_LOOKUP && !hit;
   assign beat_ok = state == ICACHE_REFILL && i_m_readdata_valid;
   assign last    = beat_ok && &beat;
   assign accept  = i_p_read && !o_p_waitrequest;
   icache_ram #(.W(TAG_W), .D(2**INDEX_W)) u_tag (
      .clk(clk), .we(last), .waddr(idx_q), .wdata(tag_q),
      .raddr(i_p_addr[OFFSET_W +: INDEX_W]), .rdata(tag_rd)
   );
   icache_ram #(.W(DATA_W), .D(2**(INDEX_W+OFFSET_W))) u_data (
      .clk(clk), .we(beat_ok), .waddr({idx_q, beat}), .wdata(i_m_readdata),
      .raddr(i_p_addr[INDEX_W+OFFSET_W-1:0]), .rdata(data_rd)
   );
   always_comb begin
      nxt                = state;
      o_p_waitrequest    = state == ICACHE_MISS_REQ || state == ICACHE_REFILL || miss;
      o_p_readdata_valid = hit || state == ICACHE_RESPOND;
      o_p_readdata       = hit ? data_rd : state == ICACHE_RESPOND ? ret : ICACHE_ZERO_WORD;
      o_m_read           = state == ICACHE_MISS_REQ;
      o_m_addr           = o_m_read ? {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}} : '0;
      o_m_burstcount     = 3'(2**OFFSET_W);
      case (state)
         ICACHE_IDLE:     nxt = accept ? ICACHE_LOOKUP : ICACHE_IDLE;
         ICACHE_LOOKUP:   nxt = !hit ? ICACHE_MISS_REQ : accept ? ICACHE_LOOKUP : ICACHE_IDLE;
         ICACHE_MISS_REQ: nxt = i_m_waitrequest ? ICACHE_MISS_REQ : ICACHE_REFILL;
         ICACHE_REFILL:   nxt = last ? ICACHE_RESPOND : ICACHE_REFILL;
         ICACHE_RESPOND:  nxt = accept ? ICACHE_LOOKUP : ICACHE_IDLE;
         default:         nxt = ICACHE_IDLE;
      endcase
   end
   // An invalidate racing a refill taints the line so stale data never becomes valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ICACHE_IDLE;
         addr_q <= '0;
         valid  <= '0;
         beat   <= '0;
         taint  <= 1'b0;
         ret    <= '0;
      end else begin
         state <= nxt;
         if (accept) addr_q <= i_p_addr;
         if (beat_ok) beat <= beat + 1'b1;
         if (beat_ok && beat == off_q) ret <= i_m_readdata;
         if (miss) taint <= 1'b0;
         else if (i_invalidate && (state == ICACHE_MISS_REQ || state == ICACHE_REFILL)) taint <= 1'b1;
         if (i_invalidate) valid <= '0;
         else if (last && !taint) valid[idx_q] <= 1'b1;
      end
   end
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed scoreboard bench; stimulus pushes expected words, a monitor pops on valid.
module tb_icache;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [24:0] i_p_addr = '0;
   logic        i_p_read = 1'b0;
   logic        i_p_write = 1'b0;
   logic [3:0]  i_p_byte_en = '0;
   logic [31:0] i_p_writedata = '0;
   logic [31:0] o_p_readdata;
   logic        o_p_readdata_valid, o_p_waitrequest;
   logic        i_invalidate = 1'b0;
   logic [24:0] o_m_addr;
   logic        o_m_read;
   logic [2:0]  o_m_burstcount;
   logic [31:0] i_m_readdata = '0;
   logic        i_m_readdata_valid = 1'b0;
   logic        i_m_waitrequest = 1'b0;
   int vectors = 0, miscompares = 0, m_reads = 0, bursts = 0;
   int stall = 0, inval_beat = -1, rst_beat = -1;
   logic [24:0] last_addr = '0;
   logic [31:0] exp_q[$];

   icache dut (
      .clk(clk), .rst(rst), .i_p_addr(i_p_addr), .i_p_read(i_p_read), .i_p_write(i_p_write),
      .i_p_byte_en(i_p_byte_en), .i_p_writedata(i_p_writedata), .o_p_readdata(o_p_readdata),
      .o_p_readdata_valid(o_p_readdata_valid), .o_p_waitrequest(o_p_waitrequest),
      .i_invalidate(i_invalidate), .o_m_addr(o_m_addr), .o_m_read(o_m_read),
      .o_m_burstcount(o_m_burstcount), .i_m_readdata(i_m_readdata),
      .i_m_readdata_valid(i_m_readdata_valid), .i_m_waitrequest(i_m_waitrequest)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: timed out", name);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a + 32'h90;
   endfunction

   always @(negedge clk)
      if (o_p_readdata_valid) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_valid: got %h expected no response", o_p_readdata);
         end else chk("readdata", o_p_readdata, exp_q.pop_front());
      end

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_readdata"}, o_p_readdata, 0);
      chk({tag, "_valid"}, 32'(o_p_readdata_valid), 0);
      chk({tag, "_waitreq"}, 32'(o_p_waitrequest), 0);
      chk({tag, "_m_read"}, 32'(o_m_read), 0);
      chk({tag, "_m_addr"}, 32'(o_m_addr), 0);
   endtask

   // Memory model: owns rst and i_invalidate so every driver of those lives in one process.
   initial begin
      logic [24:0] base;
      bit reset_hit;
      #1 chk_zero_outputs("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      forever begin
         @(negedge clk);
         if (o_m_read) begin
            m_reads++;
            base = o_m_addr;
            chk("m_addr", 32'(o_m_addr), 32'({last_addr[24:2], 2'b00}));
            chk("burstcount", 32'(o_m_burstcount), 4);
            if (stall > 0) begin
               i_m_waitrequest = 1'b1;
               for (int s = 0; s < stall; s++) begin
                  @(negedge clk);
                  chk("stall_m_read", 32'(o_m_read), 1);
                  chk("stall_m_addr", 32'(o_m_addr), 32'(base));
                  chk("stall_p_waitreq", 32'(o_p_waitrequest), 1);
               end
               i_m_waitrequest = 1'b0;
            end
            @(posedge clk);
            reset_hit = 1'b0;
            for (int b = 0; b < 4; b++) begin
               @(negedge clk);
               i_m_readdata = mem_word(32'(base) + 32'(b));
               i_m_readdata_valid = 1'b1;
               i_invalidate = (b == inval_beat);
               if (b == rst_beat) begin
                  rst = 1'b1;
                  #1 chk_zero_outputs("midrefill_reset");
                  reset_hit = 1'b1;
               end else rst = 1'b0;
               @(posedge clk);
            end
            @(negedge clk);
            i_m_readdata_valid = 1'b0;
            i_invalidate = 1'b0;
            rst = 1'b0;
            if (!reset_hit) chk("respond_after_last_beat", 32'(o_p_readdata_valid), 1);
            bursts++;
         end
      end
   end

   task automatic issue(input logic [24:0] a, input bit push, output int waits);
      @(negedge clk);
      i_p_read = 1'b1;
      i_p_addr = a;
      last_addr = a;
      waits = 0;
      while (o_p_waitrequest && waits < 200) begin
         @(negedge clk);
         waits++;
      end
      if (waits >= 200) timeout("accept");
      if (push) exp_q.push_back(mem_word(32'(a)));
      @(posedge clk);
   endtask

   task automatic drain();
      int n = 0;
      @(negedge clk);
      i_p_read = 1'b0;
      while ((exp_q.size() != 0 || o_p_waitrequest) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) timeout("drain");
   endtask

   initial begin
      int w, m0, b0;
      wait (rst == 1'b0);
      m0 = m_reads;
      issue(25'h10, 1, w);
      drain();
      chk("cold_miss_bursts", 32'(m_reads), 32'(m0 + 1));
      m0 = m_reads;
      issue(25'h11, 1, w);
      chk("stream_wait_11", 32'(w), 0);
      issue(25'h12, 1, w);
      chk("stream_wait_12", 32'(w), 0);
      issue(25'h13, 1, w);
      chk("stream_wait_13", 32'(w), 0);
      drain();
      chk("stream_no_m_read", 32'(m_reads), 32'(m0));
      issue(25'h110, 1, w);
      drain();
      chk("conflict_miss_110", 32'(m_reads), 32'(m0 + 1));
      issue(25'h10, 1, w);
      drain();
      chk("conflict_miss_10", 32'(m_reads), 32'(m0 + 2));
      stall = 5;
      issue(25'h20, 1, w);
      drain();
      stall = 0;
      inval_beat = 1;
      issue(25'h36, 1, w);
      drain();
      inval_beat = -1;
      m0 = m_reads;
      issue(25'h36, 1, w);
      drain();
      chk("tainted_line_misses", 32'(m_reads), 32'(m0 + 1));
      issue(25'h21, 1, w);
      drain();
      chk("invalidated_line_misses", 32'(m_reads), 32'(m0 + 2));
      rst_beat = 2;
      b0 = bursts;
      issue(25'h44, 0, w);
      @(negedge clk);
      i_p_read = 1'b0;
      w = 0;
      while (bursts == b0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (w >= 200) timeout("reset_burst");
      rst_beat = -1;
      repeat (3) @(negedge clk);
      chk("post_reset_idle_valid", 32'(o_p_readdata_valid), 0);
      m0 = m_reads;
      issue(25'h44, 1, w);
      drain();
      chk("post_reset_miss", 32'(m_reads), 32'(m0 + 1));
      issue(25'h47, 1, w);
      drain();
      chk("post_reset_refill_hit", 32'(m_reads), 32'(m0 + 1));
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
